// File: rtl/crossbar2_pkg.sv
// Shared encodings for the 2x2 crossbar scheduler: crossbar select codes and destination codes.
package crossbar2_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_X0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_X1 = 2'd1;

  localparam logic DEST_Y0 = 1'b0;
  localparam logic DEST_Y1 = 1'b1;

  // Grant index (0 = input 0, 1 = input 1) to crossbar select code.
  function automatic logic [SEL_W-1:0] sel_of(input logic gnt);
    return gnt ? SEL_X1 : SEL_X0;
  endfunction

endpackage

// File: rtl/crossbar2_sched_if.sv
// Handshake and crossbar-drive bundle between the scheduler and its producers/consumers.
interface crossbar2_sched_if #(
  parameter int unsigned Data_Width   = 8,
  parameter int unsigned Select_Width = 2
);

  logic                    in_valid0;
  logic [Data_Width-1:0]   in_data0;
  logic                    in_dest0;
  logic                    in_ready0;
  logic                    in_valid1;
  logic [Data_Width-1:0]   in_data1;
  logic                    in_dest1;
  logic                    in_ready1;
  logic [Data_Width-1:0]   x0;
  logic [Data_Width-1:0]   x1;
  logic [Select_Width-1:0] s0;
  logic [Select_Width-1:0] s1;
  logic                    out_valid0;
  logic                    out_ready0;
  logic                    out_valid1;
  logic                    out_ready1;

  modport master (
    output in_valid0, in_data0, in_dest0, in_valid1, in_data1, in_dest1,
    output out_ready0, out_ready1,
    input  in_ready0, in_ready1, x0, x1, s0, s1, out_valid0, out_valid1
  );

  modport slave (
    input  in_valid0, in_data0, in_dest0, in_valid1, in_data1, in_dest1,
    input  out_ready0, out_ready1,
    output in_ready0, in_ready1, x0, x1, s0, s1, out_valid0, out_valid1
  );

endinterface

// File: rtl/crossbar2_rr_arb.sv
// Per-output round-robin arbiter with a stall lock that pins the grant until the word transfers.
module crossbar2_rr_arb (
  input  logic [1:0] req_i,
  input  logic       lock_i,
  input  logic       rr_i,
  input  logic       gnt_q_i,
  input  logic       xfer_i,
  output logic       gnt_o,
  output logic       valid_o,
  output logic       rr_o,
  output logic       lock_o
);

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b11:   gnt_o = lock_i ? gnt_q_i : rr_i;
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      default: gnt_o = gnt_q_i;
    endcase
  end

  always_comb begin
    rr_o   = rr_i;
    lock_o = lock_i;
    if (xfer_i) begin
      rr_o   = ~gnt_o;
      lock_o = 1'b0;
    end else if (valid_o) begin
      // A stalled output keeps its grant so a late competitor cannot take over.
      lock_o = 1'b1;
    end
  end

endmodule

// File: rtl/crossbar2_sched.sv
// Upstream scheduler for the 2x2 crossbar: one-word buffer per input, destination routing,
// per-output round-robin arbitration and valid/ready handshakes on both sides.
module crossbar2_sched
  import crossbar2_pkg::*;
#(
  parameter int unsigned Data_Width   = 8,
  parameter int unsigned Select_Width = 2
) (
  input logic              clk,
  input logic              rst,
  crossbar2_sched_if.slave bus
);

  logic [1:0]            full_q;
  logic [1:0]            dst_q;
  logic [Data_Width-1:0] data_q [2];
  logic [1:0]            rr_q, rr_d;
  logic [1:0]            lock_q, lock_d;
  logic [1:0]            gnt_q, gnt;

  logic [1:0]            in_valid, in_dest, in_ready, out_ready, out_valid;
  logic [1:0]            xfer, drain, load;
  logic [1:0]            req [2];
  logic [Data_Width-1:0] in_data [2];

  assign in_valid   = {bus.in_valid1, bus.in_valid0};
  assign in_dest    = {bus.in_dest1, bus.in_dest0};
  assign out_ready  = {bus.out_ready1, bus.out_ready0};
  assign in_data[0] = bus.in_data0;
  assign in_data[1] = bus.in_data1;

  always_comb begin
    req[0] = {full_q[1] & (dst_q[1] == DEST_Y0), full_q[0] & (dst_q[0] == DEST_Y0)};
    req[1] = {full_q[1] & (dst_q[1] == DEST_Y1), full_q[0] & (dst_q[0] == DEST_Y1)};
  end

  for (genvar j = 0; j < 2; j++) begin : g_out
    crossbar2_rr_arb u_arb (
      .req_i   (req[j]),
      .lock_i  (lock_q[j]),
      .rr_i    (rr_q[j]),
      .gnt_q_i (gnt_q[j]),
      .xfer_i  (xfer[j]),
      .gnt_o   (gnt[j]),
      .valid_o (out_valid[j]),
      .rr_o    (rr_d[j]),
      .lock_o  (lock_d[j])
    );
  end

  assign xfer = out_valid & out_ready;

  // An input drains when its destination output transfers and has granted that input.
  always_comb begin
    drain[0] = full_q[0] & xfer[dst_q[0]] & ~gnt[dst_q[0]];
    drain[1] = full_q[1] & xfer[dst_q[1]] &  gnt[dst_q[1]];
    in_ready = ~full_q | drain;
    load     = in_valid & in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      dst_q     <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      rr_q      <= '0;
      lock_q    <= '0;
      gnt_q     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i]) begin
          data_q[i] <= in_data[i];
          dst_q[i]  <= in_dest[i];
          full_q[i] <= 1'b1;
        end else if (drain[i]) begin
          full_q[i] <= 1'b0;
        end
      end
      rr_q   <= rr_d;
      lock_q <= lock_d;
      gnt_q  <= gnt;
    end
  end

  assign bus.in_ready0  = in_ready[0];
  assign bus.in_ready1  = in_ready[1];
  assign bus.out_valid0 = out_valid[0];
  assign bus.out_valid1 = out_valid[1];
  assign bus.x0         = data_q[0];
  assign bus.x1         = data_q[1];
  assign bus.s0         = Select_Width'(sel_of(gnt[0]));
  assign bus.s1         = Select_Width'(sel_of(gnt[1]));

endmodule

// File: tb/tb_crossbar2_sched.sv
// Bench for crossbar2_sched: directed vector table, hand-written stream/reset sequences,
// and a random run scored against a queue-based model of the scheduling rules.
module tb_crossbar2_sched;
  import crossbar2_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crossbar2_sched_if #(.Data_Width(DW), .Select_Width(SW)) bus ();

  crossbar2_sched #(.Data_Width(DW), .Select_Width(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The crossbar itself: Y outputs derived from X and S.
  logic [DW-1:0] y0, y1;
  assign y0 = (bus.s0 == SEL_X1) ? bus.x1 : bus.x0;
  assign y1 = (bus.s1 == SEL_X1) ? bus.x1 : bus.x0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv0, input logic [DW-1:0] d0, input logic ds0,
                       input logic iv1, input logic [DW-1:0] d1, input logic ds1,
                       input logic or0, input logic or1);
    bus.in_valid0  = iv0;
    bus.in_data0   = d0;
    bus.in_dest0   = ds0;
    bus.in_valid1  = iv1;
    bus.in_data1   = d1;
    bus.in_dest1   = ds1;
    bus.out_ready0 = or0;
    bus.out_ready1 = or1;
  endtask

  typedef struct {
    logic iv0; logic [DW-1:0] d0; logic ds0;
    logic iv1; logic [DW-1:0] d1; logic ds1;
    logic or0; logic or1;
    logic ov0; logic ov1; logic ir0; logic ir1;
    logic [SW-1:0] s0; logic [SW-1:0] s1;
    logic [DW-1:0] y0; logic [DW-1:0] y1;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  function automatic vec_t mk(
    input logic iv0, input logic [DW-1:0] d0, input logic ds0,
    input logic iv1, input logic [DW-1:0] d1, input logic ds1,
    input logic or0, input logic or1,
    input logic ov0, input logic ov1, input logic ir0, input logic ir1,
    input logic [SW-1:0] s0, input logic [SW-1:0] s1,
    input logic [DW-1:0] ey0, input logic [DW-1:0] ey1);
    vec_t v;
    v.iv0 = iv0; v.d0 = d0; v.ds0 = ds0; v.iv1 = iv1; v.d1 = d1; v.ds1 = ds1;
    v.or0 = or0; v.or1 = or1; v.ov0 = ov0; v.ov1 = ov1; v.ir0 = ir0; v.ir1 = ir1;
    v.s0 = s0; v.s1 = s1; v.y0 = ey0; v.y1 = ey1;
    return v;
  endfunction

  // Reference model state: per-input held words, per-output arbitration history.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          dest;
  } word_t;

  word_t         mq [2][$];
  logic [1:0]    mlast, mstall, mprev, mg, mv, drn, ird;
  logic [1:0]    riv, rds, ror;
  logic [DW-1:0] rd [2];
  logic          c0, c1;

  initial begin
    // Inputs, ready, expected: ov0 ov1 ir0 ir1 s0 s1 y0 y1
    tbl[0]  = mk(F,8'h00,F, F,8'h00,F, T,T, F,F,T,T, SEL_X0,SEL_X0, 8'h00,8'h00);
    tbl[1]  = mk(T,8'h11,T, T,8'h22,F, T,T, F,F,T,T, SEL_X0,SEL_X0, 8'h00,8'h00);
    tbl[2]  = mk(F,8'h00,F, F,8'h00,F, T,T, T,T,T,T, SEL_X1,SEL_X0, 8'h22,8'h11);
    tbl[3]  = mk(F,8'h00,F, F,8'h00,F, T,T, F,F,T,T, SEL_X1,SEL_X0, 8'h00,8'h00);
    tbl[4]  = mk(T,8'hA0,F, T,8'hB0,F, T,T, F,F,T,T, SEL_X1,SEL_X0, 8'h00,8'h00);
    tbl[5]  = mk(T,8'hA1,F, T,8'hB1,F, T,T, T,F,T,F, SEL_X0,SEL_X0, 8'hA0,8'h00);
    tbl[6]  = mk(T,8'hA2,F, T,8'hB1,F, T,T, T,F,F,T, SEL_X1,SEL_X0, 8'hB0,8'h00);
    tbl[7]  = mk(T,8'hA2,F, T,8'hB2,F, T,T, T,F,T,F, SEL_X0,SEL_X0, 8'hA1,8'h00);
    tbl[8]  = mk(F,8'h00,F, T,8'hB2,F, T,T, T,F,F,T, SEL_X1,SEL_X0, 8'hB1,8'h00);
    tbl[9]  = mk(F,8'h00,F, F,8'h00,F, T,T, T,F,T,F, SEL_X0,SEL_X0, 8'hA2,8'h00);
    tbl[10] = mk(F,8'h00,F, F,8'h00,F, T,T, T,F,T,T, SEL_X1,SEL_X0, 8'hB2,8'h00);
    tbl[11] = mk(F,8'h00,F, F,8'h00,F, T,T, F,F,T,T, SEL_X1,SEL_X0, 8'h00,8'h00);
    tbl[12] = mk(F,8'h00,F, T,8'hC5,F, F,T, F,F,T,T, SEL_X1,SEL_X0, 8'h00,8'h00);
    tbl[13] = mk(F,8'h00,F, F,8'h00,F, F,T, T,F,T,F, SEL_X1,SEL_X0, 8'hC5,8'h00);
    tbl[14] = mk(F,8'h00,F, F,8'h00,F, F,T, T,F,T,F, SEL_X1,SEL_X0, 8'hC5,8'h00);
    tbl[15] = mk(T,8'hD7,F, F,8'h00,F, F,T, T,F,T,F, SEL_X1,SEL_X0, 8'hC5,8'h00);
    tbl[16] = mk(F,8'h00,F, F,8'h00,F, F,T, T,F,F,F, SEL_X1,SEL_X0, 8'hC5,8'h00);
    tbl[17] = mk(F,8'h00,F, F,8'h00,F, T,T, T,F,F,T, SEL_X1,SEL_X0, 8'hC5,8'h00);
    tbl[18] = mk(F,8'h00,F, F,8'h00,F, T,T, T,F,T,T, SEL_X0,SEL_X0, 8'hD7,8'h00);
    tbl[19] = mk(F,8'h00,F, F,8'h00,F, T,T, F,F,T,T, SEL_X0,SEL_X0, 8'h00,8'h00);

    rst = 1'b1;
    drive(F, 8'h00, F, F, 8'h00, F, T, T);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ov0", bus.out_valid0, 0);
    chk("reset ov1", bus.out_valid1, 0);
    chk("reset ir0", bus.in_ready0, 1);
    chk("reset ir1", bus.in_ready1, 1);
    chk("reset s0", bus.s0, SEL_X0);
    chk("reset s1", bus.s1, SEL_X0);
    chk("reset x0", bus.x0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      @(posedge clk); #1;
      drive(tbl[k].iv0, tbl[k].d0, tbl[k].ds0, tbl[k].iv1, tbl[k].d1, tbl[k].ds1,
            tbl[k].or0, tbl[k].or1);
      @(negedge clk);
      chk($sformatf("vec%0d ov0", k), bus.out_valid0, tbl[k].ov0);
      chk($sformatf("vec%0d ov1", k), bus.out_valid1, tbl[k].ov1);
      chk($sformatf("vec%0d ir0", k), bus.in_ready0, tbl[k].ir0);
      chk($sformatf("vec%0d ir1", k), bus.in_ready1, tbl[k].ir1);
      chk($sformatf("vec%0d s0", k), bus.s0, tbl[k].s0);
      chk($sformatf("vec%0d s1", k), bus.s1, tbl[k].s1);
      if (tbl[k].ov0) chk($sformatf("vec%0d y0", k), y0, tbl[k].y0);
      if (tbl[k].ov1) chk($sformatf("vec%0d y1", k), y1, tbl[k].y1);
    end

    // Input 0 streams to Y1: one word per cycle, one cycle latency.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      drive(T, 8'(8'hE0 + k), T, F, 8'h00, F, T, T);
      @(negedge clk);
      chk("stream ir0", bus.in_ready0, 1);
      chk("stream ov1", bus.out_valid1, (k > 0) ? 1 : 0);
      if (k > 0) chk("stream y1", y1, 8'hE0 + k - 1);
    end
    @(posedge clk); #1;
    drive(F, 8'h00, F, F, 8'h00, F, T, T);
    @(negedge clk);
    chk("stream last y1", y1, 8'hE7);
    chk("stream last ov1", bus.out_valid1, 1);

    // Reset pulsed with words buffered and a consumer stalled.
    @(posedge clk); #1;
    drive(T, 8'hF1, F, T, 8'hF2, F, F, F);
    @(posedge clk); #1;
    drive(F, 8'h00, F, F, 8'h00, F, T, T);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ov0", bus.out_valid0, 0);
    chk("midrst ir0", bus.in_ready0, 1);
    chk("midrst ir1", bus.in_ready1, 1);
    chk("midrst s0", bus.s0, SEL_X0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst ov0", bus.out_valid0, 0);
    chk("postrst ov1", bus.out_valid1, 0);

    // Random run against the model.
    mlast  = 2'b11;
    mstall = 2'b00;
    mprev  = 2'b00;
    mq[0].delete();
    mq[1].delete();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        riv[i] = 1'($urandom_range(0, 1));
        rds[i] = 1'($urandom_range(0, 1));
        ror[i] = ($urandom_range(0, 3) != 0);
        rd[i]  = 8'($urandom);
      end
      drive(riv[0], rd[0], rds[0], riv[1], rd[1], rds[1], ror[0], ror[1]);
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        c0 = (mq[0].size() != 0) && (mq[0][0].dest == j[0]);
        c1 = (mq[1].size() != 0) && (mq[1][0].dest == j[0]);
        mv[j] = c0 | c1;
        if (c0 && c1)  mg[j] = mstall[j] ? mprev[j] : ~mlast[j];
        else if (c0)   mg[j] = 1'b0;
        else if (c1)   mg[j] = 1'b1;
        else           mg[j] = mprev[j];
      end
      for (int i = 0; i < 2; i++) begin
        drn[i] = (mq[i].size() != 0) && ror[mq[i][0].dest] && (mg[mq[i][0].dest] == i[0]);
        ird[i] = (mq[i].size() == 0) || drn[i];
      end
      chk("rnd ov0", bus.out_valid0, mv[0]);
      chk("rnd ov1", bus.out_valid1, mv[1]);
      chk("rnd s0", bus.s0, sel_of(mg[0]));
      chk("rnd s1", bus.s1, sel_of(mg[1]));
      chk("rnd ir0", bus.in_ready0, ird[0]);
      chk("rnd ir1", bus.in_ready1, ird[1]);
      if (mv[0]) chk("rnd y0", y0, mq[mg[0]][0].data);
      if (mv[1]) chk("rnd y1", y1, mq[mg[1]][0].data);
      for (int j = 0; j < 2; j++) begin
        if (mv[j] && ror[j]) begin
          void'(mq[mg[j]].pop_front());
          mlast[j]  = mg[j];
          mstall[j] = 1'b0;
        end else if (mv[j]) begin
          mstall[j] = 1'b1;
        end
        mprev[j] = mg[j];
      end
      for (int i = 0; i < 2; i++) begin
        if (riv[i] && ird[i]) mq[i].push_back(word_t'{data: rd[i], dest: rds[i]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
